// File: rtl/scope_pkg.sv
// Shared constants for the oscilloscope trace renderer: screen geometry,
// plot colours and the renderer state encoding.
// Latency: n/a (package). Backpressure: n/a.
package scope_pkg;

  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;
  localparam int CENTRE_ROW = 60;
  localparam int Y_LIMIT    = 59;

  localparam logic [7:0] LAST_COL = 8'(SCREEN_W - 1);
  localparam logic [6:0] LAST_ROW = 7'(SCREEN_H - 1);
  localparam logic [6:0] CENTRE   = 7'(CENTRE_ROW);

  localparam logic [2:0] BG_COLOUR    = 3'b000;
  localparam logic [2:0] AXIS_COLOUR  = 3'b001;
  localparam logic [2:0] TRACE_COLOUR = 3'b010;
  localparam logic [2:0] GRID_COLOUR  = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_SAMPLE = 3'd2,
    S_ERASE  = 3'd3,
    S_DRAW   = 3'd4,
    S_NEXT   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

endpackage

// File: rtl/scope_trace_renderer_row_mapper.sv
// Clamps a signed 32-bit sample to +/-Y_LIMIT and maps it to a screen row
// (row = CENTRE_ROW - v, range 1..119). Latency: combinational.
// Backpressure: none. Ports: sample (32b two's complement) -> row (7b).
module scope_row_mapper
  import scope_pkg::*;
(
  input  logic [31:0] sample,
  output logic [6:0]  row
);

  logic signed [31:0] v;

  always_comb begin
    v = $signed(sample);
    if (v > Y_LIMIT) begin
      v = Y_LIMIT;
    end else if (v < -Y_LIMIT) begin
      v = -Y_LIMIT;
    end
    row = 7'(CENTRE_ROW - v);
  end

endmodule

// File: rtl/scope_trace_renderer.sv
// Per frame, sweeps 160 columns of the sample store; for each column erases
// it (axis at row 60), then draws a vertical segment prev..cur so the trace is
// continuous. First plot 3 edges after iStart is sampled; each column takes
// 124 + |prev-cur| cycles. No backpressure: one pixel per oPlot cycle.
// Ports: CLOCK_50/reset (async, active-high), iStart/iHold frame request,
// oX/iY sample store read, oVgaX/oVgaY/oColour/oPlot VGA plot port,
// oBusy/oFrameDone status.
// Build option: define SCOPE_GRID_EN to paint a grid (every 20th column,
// every 15th row) during erase.
module scope_trace_renderer
  import scope_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        iStart,
  input  logic        iHold,
  output logic [7:0]  oX,
  input  logic [31:0] iY,
  output logic [7:0]  oVgaX,
  output logic [6:0]  oVgaY,
  output logic [2:0]  oColour,
  output logic        oPlot,
  output logic        oBusy,
  output logic        oFrameDone
);

  state_t     state;
  logic [7:0] col;
  logic [6:0] row;
  logic [6:0] prev;
  logic [6:0] cur;
  logic [6:0] mapped_row;
  logic [6:0] seg_lo;
  logic [6:0] seg_hi;
  logic [2:0] erase_colour;

  // The store is addressed directly by the column register.
  assign oX = col;

  scope_row_mapper u_row_mapper (
    .sample (iY),
    .row    (mapped_row)
  );

  always_comb begin
    if (prev < cur) begin
      seg_lo = prev;
      seg_hi = cur;
    end else begin
      seg_lo = cur;
      seg_hi = prev;
    end
  end

  // Axis is checked last so it overrides the grid.
  always_comb begin
    erase_colour = BG_COLOUR;
`ifdef SCOPE_GRID_EN
    if (((col % 8'd20) == 8'd0) || ((row % 7'd15) == 7'd0)) begin
      erase_colour = GRID_COLOUR;
    end
`else
    erase_colour = BG_COLOUR;
`endif
    if (row == CENTRE) begin
      erase_colour = AXIS_COLOUR;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      col        <= 8'd0;
      row        <= 7'd0;
      prev       <= 7'd0;
      cur        <= 7'd0;
      oVgaX      <= 8'd0;
      oVgaY      <= 7'd0;
      oColour    <= 3'd0;
      oPlot      <= 1'b0;
      oBusy      <= 1'b0;
      oFrameDone <= 1'b0;
    end else begin
      oPlot      <= 1'b0;
      oFrameDone <= 1'b0;
      case (state)
        S_IDLE: begin
          oBusy <= 1'b0;
          if (iStart && !iHold) begin
            col   <= 8'd0;
            oBusy <= 1'b1;
            state <= S_FETCH;
          end
        end
        // oX is stable for this cycle so iY settles before SAMPLE.
        S_FETCH: begin
          state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          cur <= mapped_row;
          if (col == 8'd0) begin
            prev <= mapped_row;
          end
          row   <= 7'd0;
          state <= S_ERASE;
        end
        S_ERASE: begin
          oPlot   <= 1'b1;
          oVgaX   <= col;
          oVgaY   <= row;
          oColour <= erase_colour;
          if (row == LAST_ROW) begin
            row   <= seg_lo;
            state <= S_DRAW;
          end else begin
            row <= row + 7'd1;
          end
        end
        S_DRAW: begin
          oPlot   <= 1'b1;
          oVgaX   <= col;
          oVgaY   <= row;
          oColour <= TRACE_COLOUR;
          if (row == seg_hi) begin
            state <= S_NEXT;
          end else begin
            row <= row + 7'd1;
          end
        end
        S_NEXT: begin
          prev <= cur;
          if (col == LAST_COL) begin
            state <= S_DONE;
          end else begin
            col   <= col + 8'd1;
            state <= S_FETCH;
          end
        end
        // oBusy stays high through the done pulse and drops in IDLE.
        S_DONE: begin
          oFrameDone <= 1'b1;
          state      <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scope_trace_renderer.sv
// Self-checking bench for scope_trace_renderer: a behavioural model expands
// each frame's samples into the full expected plot list and frame length;
// a negedge monitor compares every plot against that list.
module tb_scope_trace_renderer;

  localparam logic [2:0] C_BG    = 3'b000;
  localparam logic [2:0] C_AXIS  = 3'b001;
  localparam logic [2:0] C_TRACE = 3'b010;
  localparam logic [2:0] C_GRID  = 3'b011;

  logic        CLOCK_50;
  logic        reset;
  logic        iStart;
  logic        iHold;
  logic [7:0]  oX;
  logic [31:0] iY;
  logic [7:0]  oVgaX;
  logic [6:0]  oVgaY;
  logic [2:0]  oColour;
  logic        oPlot;
  logic        oBusy;
  logic        oFrameDone;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } plot_t;

  logic [31:0] mem [160];
  plot_t       exp_q [$];
  plot_t       mon_e;
  bit          mon_en;
  int          trace_cnt [160];
  int          trace_first_row [160];
  int          grid20_cnt;
  int          n_chk;
  int          n_pass;

  scope_trace_renderer dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .iStart     (iStart),
    .iHold      (iHold),
    .oX         (oX),
    .iY         (iY),
    .oVgaX      (oVgaX),
    .oVgaY      (oVgaY),
    .oColour    (oColour),
    .oPlot      (oPlot),
    .oBusy      (oBusy),
    .oFrameDone (oFrameDone)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  // Sample store: combinational read at oX.
  always_comb begin
    iY = 32'd0;
    if (oX < 8'd160) iY = mem[oX];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // ---------------- behavioural model ----------------
  function automatic int map_row(input logic [31:0] y);
    int v;
    v = $signed(y);
    if (v > 59) v = 59;
    if (v < -59) v = -59;
    return 60 - v;
  endfunction

  function automatic logic [2:0] erase_col(input int c, input int r);
    if (r == 60) return C_AXIS;
`ifdef SCOPE_GRID_EN
    if ((c % 20) == 0 || (r % 15) == 0) return C_GRID;
`endif
    return C_BG;
  endfunction

  task automatic build_expected(output int cycles);
    int prev_r, cur_r, lo, hi;
    plot_t p;
    exp_q.delete();
    cycles = 1;
    prev_r = 0;
    for (int c = 0; c < 160; c++) begin
      trace_cnt[c] = 0;
      trace_first_row[c] = -1;
    end
    grid20_cnt = 0;
    for (int c = 0; c < 160; c++) begin
      cur_r = map_row(mem[c]);
      if (c == 0) prev_r = cur_r;
      for (int r = 0; r < 120; r++) begin
        p.x = 8'(c); p.y = 7'(r); p.c = erase_col(c, r);
        exp_q.push_back(p);
      end
      lo = (prev_r < cur_r) ? prev_r : cur_r;
      hi = (prev_r < cur_r) ? cur_r : prev_r;
      for (int r = lo; r <= hi; r++) begin
        p.x = 8'(c); p.y = 7'(r); p.c = C_TRACE;
        exp_q.push_back(p);
      end
      cycles += 124 + (hi - lo);
      prev_r = cur_r;
    end
  endtask

  // ---------------- plot stream monitor ----------------
  always @(negedge CLOCK_50) begin
    if (mon_en && oPlot) begin
      if (exp_q.size() == 0) begin
        chk("extra_plot", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("plot_xyc", int'({oVgaX, oVgaY, oColour}), int'(mon_e));
      end
      if (oColour == C_TRACE) begin
        if (trace_cnt[oVgaX] == 0) trace_first_row[oVgaX] = int'(oVgaY);
        trace_cnt[oVgaX]++;
      end
      if (oVgaX == 8'd20 && oColour == C_GRID) grid20_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic fill_random();
    int v;
    for (int c = 0; c < 160; c++) begin
      if ($urandom_range(0, 9) == 0) mem[c] = $urandom();
      else begin
        v = int'($urandom_range(0, 24)) - 12;
        mem[c] = 32'(v);
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge CLOCK_50);
    iStart = 1'b1;
    @(posedge CLOCK_50);
    #1 iStart = 1'b0;
  endtask

  task automatic run_frame(input int poke_col, input int exp_literal);
    int exp_cycles, cnt, first;
    bit done, poked, busy_at_done;
    build_expected(exp_cycles);
    mon_en = 1'b1;
    pulse_start();
    cnt = 0; first = -1; done = 0; poked = 0; busy_at_done = 0;
    while (!done && cnt < 60000) begin
      @(posedge CLOCK_50);
      cnt++;
      #1;
      if (iStart) iStart = 1'b0;
      if (cnt == 1) chk("busy_after_start", int'(oBusy), 1);
      if (oPlot && first < 0) begin
        first = cnt;
        chk("first_plot_xy", int'({oVgaX, oVgaY}), 0);
      end
      if (poke_col >= 0 && !poked && oPlot && oColour == C_TRACE && int'(oVgaX) == poke_col) begin
        iStart = 1'b1;
        iHold  = 1'b1;
        poked  = 1;
      end
      if (oFrameDone) begin
        done = 1;
        busy_at_done = oBusy;
      end
    end
    chk("frame_done_seen", int'(done), 1);
    chk("first_plot_latency", first, 3);
    chk("frame_cycles", cnt, exp_cycles);
    if (exp_literal >= 0) chk("frame_cycles_literal", cnt, exp_literal);
    chk("busy_during_done", int'(busy_at_done), 1);
    @(posedge CLOCK_50);
    #1;
    chk("busy_after_done", int'(oBusy), 0);
    chk("done_one_cycle", int'(oFrameDone), 0);
    iHold = 1'b0;
    repeat (5) @(posedge CLOCK_50);
    #1;
    chk("no_requeued_frame", int'(oBusy), 0);
    chk("leftover_plots", exp_q.size(), 0);
    mon_en = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int dummy, bad_plot, bad_busy, bad_x, cnt;
    bit found;
    n_chk = 0; n_pass = 0; mon_en = 0;
    reset = 1'b1; iStart = 1'b0; iHold = 1'b0;
    for (int c = 0; c < 160; c++) mem[c] = 32'd0;

    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("rst_oX", int'(oX), 0);
    chk("rst_oVgaX", int'(oVgaX), 0);
    chk("rst_oVgaY", int'(oVgaY), 0);
    chk("rst_oColour", int'(oColour), 0);
    chk("rst_oPlot", int'(oPlot), 0);
    chk("rst_oBusy", int'(oBusy), 0);
    chk("rst_oFrameDone", int'(oFrameDone), 0);
    @(negedge CLOCK_50);
    reset = 1'b0;

    // Pin the model's row mapping with hand-computed values.
    chk("map_plus100", map_row(32'd100), 1);
    chk("map_minus100", map_row(32'hFFFFFF9C), 119);
    chk("map_zero", map_row(32'd0), 60);
    chk("map_plus20", map_row(32'd20), 40);
    chk("map_minus59", map_row(32'hFFFFFFC5), 119);
    chk("map_big_neg", map_row(32'h80000000), 119);

    // Hold: request ignored.
    iHold = 1'b1;
    pulse_start();
    bad_plot = 0; bad_busy = 0; bad_x = 0;
    repeat (20) begin
      @(posedge CLOCK_50);
      #1;
      if (oPlot) bad_plot++;
      if (oBusy) bad_busy++;
      if (oX != 8'd0) bad_x++;
    end
    chk("hold_no_plot", bad_plot, 0);
    chk("hold_no_busy", bad_busy, 0);
    chk("hold_oX_zero", bad_x, 0);
    iHold = 1'b0;

    // Flat trace.
    for (int c = 0; c < 160; c++) mem[c] = 32'd0;
    run_frame(-1, 19841);
    chk("flat_trace_cnt_col5", trace_cnt[5], 1);
    chk("flat_trace_row_col5", trace_first_row[5], 60);
`ifdef SCOPE_GRID_EN
    chk("grid_col20_count", grid20_cnt, 119);
`else
    chk("grid_col20_count", grid20_cnt, 0);
`endif

    // Reset during column 37 erase.
    fill_random();
    build_expected(dummy);
    mon_en = 1'b1;
    pulse_start();
    found = 0; cnt = 0;
    while (!found && cnt < 10000) begin
      @(posedge CLOCK_50);
      cnt++;
      #1;
      if (oPlot && oVgaX == 8'd37 && oColour != C_TRACE) found = 1;
    end
    chk("reached_col37", int'(found), 1);
    #1 reset = 1'b1;
    #1;
    chk("midrst_oPlot", int'(oPlot), 0);
    chk("midrst_oBusy", int'(oBusy), 0);
    chk("midrst_oX", int'(oX), 0);
    mon_en = 1'b0;
    exp_q.delete();
    @(negedge CLOCK_50);
    reset = 1'b0;

    // Clamping plus random columns.
    fill_random();
    mem[0] = 32'd100;
    mem[1] = 32'hFFFFFF9C;
    run_frame(-1, -1);
    chk("clamp_col0_row", trace_first_row[0], 1);
    chk("clamp_col0_cnt", trace_cnt[0], 1);
    chk("clamp_col1_cnt", trace_cnt[1], 119);
    chk("clamp_col1_first", trace_first_row[1], 1);

    // Step, with a start request and hold change during DRAW of column 80.
    for (int c = 0; c < 160; c++) mem[c] = (c < 80) ? 32'd0 : 32'd20;
    run_frame(80, 19861);
    chk("step_col80_cnt", trace_cnt[80], 21);
    chk("step_col80_first", trace_first_row[80], 40);
    chk("step_col81_cnt", trace_cnt[81], 1);
    chk("step_col81_row", trace_first_row[81], 40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
